instr_step_sequencer: RTL and testbench

- Parametrised control-step sequencer that drives the datapath's control strobes for the immediate/memory instruction class: ld, ldi, st, addi, andi, ori.
- Replaces hand-sequenced T0..T5 strobe patterns with an FSM.
- Adds configurable cycles per step, memory-ready handshaking, variable-length sequences (T0..T7) and illegal-opcode detection.
- Sits between the instruction register opcode field and the datapath control inputs.

---
 rtl/instr_step_sequencer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_instr_step_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_step_sequencer.sv
// Control-step sequencer for the immediate/memory instruction class (ld, ldi, st, addi, andi, ori).
// Walks T0..T7 with a configurable number of cycles per step and waits for memory on the memory steps.
module instr_step_sequencer #(
    parameter int STEP_CYCLES = 2,
    parameter int OPCODE_W    = 5,
    parameter int STATE_W     = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [OPCODE_W-1:0] ir_opcode,
    output logic                pc_out,
    output logic                zlo_out,
    output logic                mdr_out,
    output logic                ba_out,
    output logic                r_out,
    output logic                c_sign_extended_out,
    output logic                mar_enable,
    output logic                pc_enable,
    output logic                pc_increment,
    output logic                mdr_enable,
    output logic                ir_enable,
    output logic                y_enable,
    output logic                z_enable,
    output logic                r_in,
    output logic                gra,
    output logic                grb,
    output logic                read,
    output logic                ram_write,
    output logic [OPCODE_W-1:0] alu_op,
    output logic                done,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(5'b00000);
    localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(5'b00001);
    localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(5'b00010);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5'b01100);
    localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(5'b01101);
    localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(5'b01110);

    localparam logic [OPCODE_W-1:0] ALU_ADD = OPCODE_W'(5'b00011);
    localparam logic [OPCODE_W-1:0] ALU_AND = OPCODE_W'(5'b01010);
    localparam logic [OPCODE_W-1:0] ALU_OR  = OPCODE_W'(5'b01011);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_FAULT = 4'd15
    } state_t;

    function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
        logic legal;
        case (op)
            OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ANDI, OP_ORI: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic [OPCODE_W-1:0] alu_code(input logic [OPCODE_W-1:0] op);
        logic [OPCODE_W-1:0] code;
        case (op)
            OP_ANDI: code = ALU_AND;
            OP_ORI:  code = ALU_OR;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [OPCODE_W-1:0] r_opcode;

    state_t              w_state_nx;
    logic [CNT_W-1:0]    w_cnt_nx;
    logic                w_last;
    logic                w_first_t3;
    logic [OPCODE_W-1:0] w_op;
    logic                w_legal;
    logic                w_is_ld;
    logic                w_is_st;
    logic                w_mem_step;
    logic                w_adv;
    logic                w_final;

    // The opcode is only trustworthy from T3 on, so the first T3 cycle decodes the live field.
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_first_t3 = (r_state == S_T3) && (r_cnt == CNT_ZERO);
    assign w_op       = w_first_t3 ? ir_opcode : r_opcode;
    assign w_legal    = op_is_legal(w_op);
    assign w_is_ld    = (w_op == OP_LD);
    assign w_is_st    = (w_op == OP_ST);
    assign w_mem_step = (r_state == S_T1) ||
                        ((r_state == S_T6) && w_is_ld) ||
                        ((r_state == S_T7) && w_is_st);
    assign w_adv      = w_last && (!w_mem_step || mem_ready);
    assign w_final    = ((r_state == S_T5) && !w_is_ld && !w_is_st) || (r_state == S_T7);
    assign state      = STATE_W'(r_state);

    // State, step counter and latched opcode registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= S_IDLE;
            r_cnt    <= CNT_ZERO;
            r_opcode <= {OPCODE_W{1'b0}};
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_opcode <= w_first_t3 ? ir_opcode : r_opcode;
        end
    end

    // Next-state and step-counter logic.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = CNT_ZERO;
                if (run) begin
                    w_state_nx = S_T0;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_FAULT: begin
                w_state_nx = S_FAULT;
                w_cnt_nx   = CNT_ZERO;
            end
            S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (w_first_t3 && !w_legal) begin
                    w_state_nx = S_FAULT;
                    w_cnt_nx   = CNT_ZERO;
                end else if (w_adv) begin
                    w_cnt_nx = CNT_ZERO;
                    if (w_final) begin
                        w_state_nx = run ? S_T0 : S_IDLE;
                    end else begin
                        w_state_nx = state_t'(r_state + 4'd1);
                    end
                end else if (!w_last) begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end else begin
                    w_cnt_nx = r_cnt;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = CNT_ZERO;
            end
        endcase
    end

    // Strobe decode; load enables and done fire only in the cycle the step advances.
    always_comb begin
        pc_out              = 1'b0;
        zlo_out             = 1'b0;
        mdr_out             = 1'b0;
        ba_out              = 1'b0;
        r_out               = 1'b0;
        c_sign_extended_out = 1'b0;
        mar_enable          = 1'b0;
        pc_enable           = 1'b0;
        pc_increment        = 1'b0;
        mdr_enable          = 1'b0;
        ir_enable           = 1'b0;
        y_enable            = 1'b0;
        z_enable            = 1'b0;
        r_in                = 1'b0;
        gra                 = 1'b0;
        grb                 = 1'b0;
        read                = 1'b0;
        ram_write           = 1'b0;
        alu_op              = {OPCODE_W{1'b0}};
        done                = 1'b0;
        illegal             = 1'b0;
        case (r_state)
            S_T0: begin
                pc_out       = 1'b1;
                mar_enable   = w_adv;
                pc_increment = w_adv;
                z_enable     = w_adv;
            end
            S_T1: begin
                zlo_out    = 1'b1;
                read       = 1'b1;
                pc_enable  = w_adv;
                mdr_enable = w_adv;
            end
            S_T2: begin
                mdr_out   = 1'b1;
                ir_enable = w_adv;
            end
            S_T3: begin
                if (w_legal) begin
                    grb      = 1'b1;
                    ba_out   = 1'b1;
                    y_enable = w_adv;
                end else begin
                    illegal  = 1'b1;
                end
            end
            S_T4: begin
                c_sign_extended_out = 1'b1;
                z_enable            = w_adv;
                alu_op              = alu_code(r_opcode);
            end
            S_T5: begin
                zlo_out = 1'b1;
                if (w_is_ld || w_is_st) begin
                    mar_enable = w_adv;
                end else begin
                    gra  = 1'b1;
                    r_in = w_adv;
                    done = w_adv;
                end
            end
            S_T6: begin
                if (w_is_ld) begin
                    read       = 1'b1;
                    mdr_enable = w_adv;
                end else begin
                    gra        = 1'b1;
                    r_out      = 1'b1;
                    mdr_enable = w_adv;
                end
            end
            S_T7: begin
                done = w_adv;
                if (w_is_ld) begin
                    mdr_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = w_adv;
                end else begin
                    ram_write = 1'b1;
                end
            end
            S_FAULT: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_step_sequencer.sv
// Directed bench: one sequencer at two cycles per step and one at one cycle per step,
// checked every cycle against hand-computed state, alu_op and strobe patterns.
module tb_instr_step_sequencer;

    localparam logic [19:0] B_PC_OUT = 20'h80000;
    localparam logic [19:0] B_ZLO    = 20'h40000;
    localparam logic [19:0] B_MDROUT = 20'h20000;
    localparam logic [19:0] B_BA     = 20'h10000;
    localparam logic [19:0] B_R_OUT  = 20'h08000;
    localparam logic [19:0] B_CSE    = 20'h04000;
    localparam logic [19:0] B_MAR_EN = 20'h02000;
    localparam logic [19:0] B_PC_EN  = 20'h01000;
    localparam logic [19:0] B_PC_INC = 20'h00800;
    localparam logic [19:0] B_MDR_EN = 20'h00400;
    localparam logic [19:0] B_IR_EN  = 20'h00200;
    localparam logic [19:0] B_Y_EN   = 20'h00100;
    localparam logic [19:0] B_Z_EN   = 20'h00080;
    localparam logic [19:0] B_R_IN   = 20'h00040;
    localparam logic [19:0] B_GRA    = 20'h00020;
    localparam logic [19:0] B_GRB    = 20'h00010;
    localparam logic [19:0] B_READ   = 20'h00008;
    localparam logic [19:0] B_RAM_WR = 20'h00004;
    localparam logic [19:0] B_DONE   = 20'h00002;
    localparam logic [19:0] B_ILL    = 20'h00001;
    localparam logic [19:0] B_NONE   = 20'h00000;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NEG  = 5'b10001;

    localparam logic [4:0] A_0   = 5'b00000;
    localparam logic [4:0] A_ADD = 5'b00011;
    localparam logic [4:0] A_AND = 5'b01010;
    localparam logic [4:0] A_OR  = 5'b01011;

    localparam logic [19:0] P_T0   = B_PC_OUT | B_MAR_EN | B_PC_INC | B_Z_EN;
    localparam logic [19:0] P_T1H  = B_ZLO | B_READ;
    localparam logic [19:0] P_T1   = B_ZLO | B_READ | B_PC_EN | B_MDR_EN;
    localparam logic [19:0] P_T2   = B_MDROUT | B_IR_EN;
    localparam logic [19:0] P_T3   = B_GRB | B_BA | B_Y_EN;
    localparam logic [19:0] P_T4   = B_CSE | B_Z_EN;
    localparam logic [19:0] P_T5I  = B_ZLO | B_GRA | B_R_IN | B_DONE;
    localparam logic [19:0] P_T5M  = B_ZLO | B_MAR_EN;

    logic       clk = 1'b0;
    logic       clr;
    logic       run1, run2, mr1, mr2;
    logic [4:0] op1, op2;
    wire [19:0] s1, s2;
    wire [4:0]  a1, a2;
    wire [3:0]  st1, st2;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    instr_step_sequencer #(.STEP_CYCLES(2), .OPCODE_W(5), .STATE_W(4)) u_dut2 (
        .clk(clk), .clr(clr), .run(run2), .mem_ready(mr2), .ir_opcode(op2),
        .pc_out(s2[19]), .zlo_out(s2[18]), .mdr_out(s2[17]), .ba_out(s2[16]),
        .r_out(s2[15]), .c_sign_extended_out(s2[14]), .mar_enable(s2[13]),
        .pc_enable(s2[12]), .pc_increment(s2[11]), .mdr_enable(s2[10]),
        .ir_enable(s2[9]), .y_enable(s2[8]), .z_enable(s2[7]), .r_in(s2[6]),
        .gra(s2[5]), .grb(s2[4]), .read(s2[3]), .ram_write(s2[2]),
        .alu_op(a2), .done(s2[1]), .illegal(s2[0]), .state(st2)
    );

    instr_step_sequencer #(.STEP_CYCLES(1), .OPCODE_W(5), .STATE_W(4)) u_dut1 (
        .clk(clk), .clr(clr), .run(run1), .mem_ready(mr1), .ir_opcode(op1),
        .pc_out(s1[19]), .zlo_out(s1[18]), .mdr_out(s1[17]), .ba_out(s1[16]),
        .r_out(s1[15]), .c_sign_extended_out(s1[14]), .mar_enable(s1[13]),
        .pc_enable(s1[12]), .pc_increment(s1[11]), .mdr_enable(s1[10]),
        .ir_enable(s1[9]), .y_enable(s1[8]), .z_enable(s1[7]), .r_in(s1[6]),
        .gra(s1[5]), .grb(s1[4]), .read(s1[3]), .ram_write(s1[2]),
        .alu_op(a1), .done(s1[1]), .illegal(s1[0]), .state(st1)
    );

    task automatic chk(input string tag, input bit sel, input logic [3:0] es,
                       input logic [19:0] ev, input logic [4:0] ea);
        logic [28:0] obs;
        logic [28:0] exp_v;
        obs   = sel ? {st1, a1, s1} : {st2, a2, s2};
        exp_v = {es, ea, ev};
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed state=%0d alu=%b strobes=%h, expected state=%0d alu=%b strobes=%h",
                   tag, obs[28:25], obs[24:20], obs[19:0], es, ea, ev);
        end
    endtask

    // Drive mem_ready for the cycle, check at the falling edge, then step past the rising edge.
    task automatic cyc(input string tag, input bit sel, input logic mr, input logic [3:0] es,
                       input logic [19:0] ev, input logic [4:0] ea);
        if (sel) mr1 = mr; else mr2 = mr;
        @(negedge clk);
        chk(tag, sel, es, ev, ea);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b0; run1 = 1'b0; run2 = 1'b0; mr1 = 1'b0; mr2 = 1'b0;
        op1 = OP_LD; op2 = OP_LDI;
        @(posedge clk);
        #1;
        chk("reset dut1", 1'b1, 4'd0, B_NONE, A_0);
        cyc("reset dut2", 1'b0, 1'b1, 4'd0, B_NONE, A_0);

        // ldi at two cycles per step, memory always ready.
        clr = 1'b1; run2 = 1'b1;
        cyc("ldi idle",  1'b0, 1'b1, 4'd0, B_NONE, A_0);
        cyc("ldi T0a",   1'b0, 1'b1, 4'd1, B_PC_OUT, A_0);
        cyc("ldi T0b",   1'b0, 1'b1, 4'd1, P_T0, A_0);
        cyc("ldi T1a",   1'b0, 1'b1, 4'd2, P_T1H, A_0);
        cyc("ldi T1b",   1'b0, 1'b1, 4'd2, P_T1, A_0);
        cyc("ldi T2a",   1'b0, 1'b1, 4'd3, B_MDROUT, A_0);
        cyc("ldi T2b",   1'b0, 1'b1, 4'd3, P_T2, A_0);
        cyc("ldi T3a",   1'b0, 1'b1, 4'd4, B_GRB | B_BA, A_0);
        cyc("ldi T3b",   1'b0, 1'b1, 4'd4, P_T3, A_0);
        cyc("ldi T4a",   1'b0, 1'b1, 4'd5, B_CSE, A_ADD);
        cyc("ldi T4b",   1'b0, 1'b1, 4'd5, P_T4, A_ADD);
        cyc("ldi T5a",   1'b0, 1'b1, 4'd6, B_ZLO | B_GRA, A_0);
        cyc("ldi T5b",   1'b0, 1'b1, 4'd6, P_T5I, A_0);
        cyc("ldi nextT0",1'b0, 1'b1, 4'd1, B_PC_OUT, A_0);

        // Second ldi, interrupted by an asynchronous clear in the middle of T4.
        cyc("ldi2 T0b",  1'b0, 1'b1, 4'd1, P_T0, A_0);
        cyc("ldi2 T1a",  1'b0, 1'b1, 4'd2, P_T1H, A_0);
        cyc("ldi2 T1b",  1'b0, 1'b1, 4'd2, P_T1, A_0);
        cyc("ldi2 T2a",  1'b0, 1'b1, 4'd3, B_MDROUT, A_0);
        cyc("ldi2 T2b",  1'b0, 1'b1, 4'd3, P_T2, A_0);
        cyc("ldi2 T3a",  1'b0, 1'b1, 4'd4, B_GRB | B_BA, A_0);
        cyc("ldi2 T3b",  1'b0, 1'b1, 4'd4, P_T3, A_0);
        cyc("ldi2 T4a",  1'b0, 1'b1, 4'd5, B_CSE, A_ADD);
        chk("ldi2 T4b pre-clr", 1'b0, 4'd5, P_T4, A_ADD);
        #1 clr = 1'b0;
        #1 chk("clr async", 1'b0, 4'd0, B_NONE, A_0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        cyc("restart T0a", 1'b0, 1'b1, 4'd1, B_PC_OUT, A_0);
        cyc("restart T0b", 1'b0, 1'b1, 4'd1, P_T0, A_0);
        run2 = 1'b0;

        // ld at one cycle per step: mem_ready low 3 cycles in T1 and 2 cycles in T6.
        run1 = 1'b1; op1 = OP_LD;
        cyc("ld idle",   1'b1, 1'b1, 4'd0, B_NONE, A_0);
        cyc("ld T0",     1'b1, 1'b1, 4'd1, P_T0, A_0);
        cyc("ld T1w1",   1'b1, 1'b0, 4'd2, P_T1H, A_0);
        cyc("ld T1w2",   1'b1, 1'b0, 4'd2, P_T1H, A_0);
        cyc("ld T1w3",   1'b1, 1'b0, 4'd2, P_T1H, A_0);
        cyc("ld T1rdy",  1'b1, 1'b1, 4'd2, P_T1, A_0);
        cyc("ld T2",     1'b1, 1'b0, 4'd3, P_T2, A_0);
        cyc("ld T3",     1'b1, 1'b0, 4'd4, P_T3, A_0);
        cyc("ld T4",     1'b1, 1'b0, 4'd5, P_T4, A_ADD);
        cyc("ld T5",     1'b1, 1'b1, 4'd6, P_T5M, A_0);
        cyc("ld T6w1",   1'b1, 1'b0, 4'd7, B_READ, A_0);
        cyc("ld T6w2",   1'b1, 1'b0, 4'd7, B_READ, A_0);
        cyc("ld T6rdy",  1'b1, 1'b1, 4'd7, B_READ | B_MDR_EN, A_0);
        cyc("ld T7",     1'b1, 1'b0, 4'd8, B_MDROUT | B_GRA | B_R_IN | B_DONE, A_0);

        // st back to back; mem_ready low in T6 must not matter, T7 holds ram_write.
        op1 = OP_ST;
        cyc("st T0",     1'b1, 1'b1, 4'd1, P_T0, A_0);
        cyc("st T1",     1'b1, 1'b1, 4'd2, P_T1, A_0);
        cyc("st T2",     1'b1, 1'b1, 4'd3, P_T2, A_0);
        cyc("st T3",     1'b1, 1'b1, 4'd4, P_T3, A_0);
        cyc("st T4",     1'b1, 1'b1, 4'd5, P_T4, A_ADD);
        cyc("st T5",     1'b1, 1'b1, 4'd6, P_T5M, A_0);
        cyc("st T6",     1'b1, 1'b0, 4'd7, B_GRA | B_R_OUT | B_MDR_EN, A_0);
        cyc("st T7w1",   1'b1, 1'b0, 4'd8, B_RAM_WR, A_0);
        cyc("st T7w2",   1'b1, 1'b0, 4'd8, B_RAM_WR, A_0);
        cyc("st T7rdy",  1'b1, 1'b1, 4'd8, B_RAM_WR | B_DONE, A_0);

        // andi then ori; run drops during ori, which still completes.
        op1 = OP_ANDI;
        cyc("andi T0",   1'b1, 1'b1, 4'd1, P_T0, A_0);
        cyc("andi T1",   1'b1, 1'b1, 4'd2, P_T1, A_0);
        cyc("andi T2",   1'b1, 1'b1, 4'd3, P_T2, A_0);
        cyc("andi T3",   1'b1, 1'b1, 4'd4, P_T3, A_0);
        cyc("andi T4",   1'b1, 1'b1, 4'd5, P_T4, A_AND);
        cyc("andi T5",   1'b1, 1'b1, 4'd6, P_T5I, A_0);
        op1 = OP_ORI;
        cyc("ori T0",    1'b1, 1'b1, 4'd1, P_T0, A_0);
        cyc("ori T1",    1'b1, 1'b1, 4'd2, P_T1, A_0);
        cyc("ori T2",    1'b1, 1'b1, 4'd3, P_T2, A_0);
        run1 = 1'b0;
        cyc("ori T3",    1'b1, 1'b1, 4'd4, P_T3, A_0);
        cyc("ori T4",    1'b1, 1'b1, 4'd5, P_T4, A_OR);
        cyc("ori T5",    1'b1, 1'b1, 4'd6, P_T5I, A_0);
        cyc("ori idle",  1'b1, 1'b1, 4'd0, B_NONE, A_0);

        // Illegal opcode: FAULT one cycle after T3 begins, held until clr.
        run1 = 1'b1; op1 = OP_NEG;
        cyc("neg idle",  1'b1, 1'b1, 4'd0, B_NONE, A_0);
        cyc("neg T0",    1'b1, 1'b1, 4'd1, P_T0, A_0);
        cyc("neg T1",    1'b1, 1'b1, 4'd2, P_T1, A_0);
        cyc("neg T2",    1'b1, 1'b1, 4'd3, P_T2, A_0);
        cyc("neg T3",    1'b1, 1'b1, 4'd4, B_ILL, A_0);
        cyc("neg fault1",1'b1, 1'b1, 4'd15, B_ILL, A_0);
        cyc("neg fault2",1'b1, 1'b1, 4'd15, B_ILL, A_0);
        cyc("neg fault3",1'b1, 1'b1, 4'd15, B_ILL, A_0);
        clr = 1'b0;
        #1 chk("fault clr", 1'b1, 4'd0, B_NONE, A_0);
        @(negedge clk);
        chk("fault clr held", 1'b1, 4'd0, B_NONE, A_0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
